// File: rtl/pipeline_pkg.sv
// Shared constants for the MIPS pipeline: datapath width, reset vector,
// sequential PC increment and the PC-stage state encoding.
package pipeline_pkg;

    localparam int              DEFAULT_NB_DATA  = 32;
    localparam logic [31:0]     DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0]     DEFAULT_PC_STEP  = 32'd4;

    typedef enum logic {
        PC_RUN    = 1'b0,
        PC_HALTED = 1'b1
    } pc_state_e;

endpackage

// File: rtl/adder.sv
// Plain modulo-2^NB_DATA adder shared across the datapath.
module adder #(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] i_data_A,
    input  logic [NB_DATA-1:0] i_data_B,
    output logic [NB_DATA-1:0] o_result
);

    assign o_result = i_data_A + i_data_B;

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, PC+4 adder, next-PC selection under
// stall/debug control, and the sticky halt state.
module pc_unit
    import pipeline_pkg::*;
#(
    parameter int                 NB_DATA  = DEFAULT_NB_DATA,
    parameter logic [NB_DATA-1:0] RESET_PC = DEFAULT_RESET_PC[NB_DATA-1:0],
    parameter logic [NB_DATA-1:0] PC_STEP  = DEFAULT_PC_STEP[NB_DATA-1:0]
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_stall,
    input  logic               i_halt,
    input  logic               i_branch_taken,
    input  logic [NB_DATA-1:0] i_branch_target,
    input  logic               i_jump,
    input  logic [NB_DATA-1:0] i_jump_target,
    output logic [NB_DATA-1:0] o_pc,
    output logic [NB_DATA-1:0] o_pc_plus4,
    output logic               o_halted,
    output logic               o_misaligned
);

    pc_state_e          state, state_next;
    logic [NB_DATA-1:0] pc_next;
    logic               misaligned_next;
    logic               advance;

    adder #(.NB_DATA(NB_DATA)) u_pc_adder (
        .i_data_A (o_pc),
        .i_data_B (PC_STEP),
        .o_result (o_pc_plus4)
    );

    assign advance  = i_enable && !i_stall && (state == PC_RUN);
    assign o_halted = (state == PC_HALTED);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        pc_next         = o_pc;
        state_next      = state;
        misaligned_next = 1'b0;

        if (advance) begin
            // A redirect squashes the HALT fetched on the wrong path.
            if (i_branch_taken) begin
                pc_next         = {i_branch_target[NB_DATA-1:2], 2'b00};
                misaligned_next = |i_branch_target[1:0];
            end else if (i_jump) begin
                pc_next         = {i_jump_target[NB_DATA-1:2], 2'b00};
                misaligned_next = |i_jump_target[1:0];
            end else if (i_halt) begin
                state_next = PC_HALTED;
            end else begin
                pc_next = o_pc_plus4;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_reset) begin
            o_pc         <= RESET_PC;
            state        <= PC_RUN;
            o_misaligned <= 1'b0;
        end else begin
            o_pc         <= pc_next;
            state        <= state_next;
            o_misaligned <= misaligned_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit: sequential fetch, stall, redirect
// priority, misalignment pulse, wraparound, halt, debug enable and reset.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        halt;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misaligned;

    int tests;
    int fails;

    pc_unit dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_enable        (enable),
        .i_stall         (stall),
        .i_halt          (halt),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .o_pc            (pc),
        .o_pc_plus4      (pc_plus4),
        .o_halted        (halted),
        .o_misaligned    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] exp_pc,
                               input logic exp_halted, input logic exp_mis);
        check({tag, ".pc"},         pc,                 exp_pc);
        check({tag, ".pc_plus4"},   pc_plus4,           exp_pc + 32'd4);
        check({tag, ".halted"},     {31'd0, halted},    {31'd0, exp_halted});
        check({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, exp_mis});
    endtask

    task automatic clear_ctrl();
        stall        = 1'b0;
        halt         = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        enable = 1'b0;
        clear_ctrl();
        branch_target = 32'h0;
        jump_target   = 32'h0;

        tick();
        check_state("reset", 32'h0, 1'b0, 1'b0);

        reset  = 1'b0;
        enable = 1'b1;
        tick(); check_state("seq1", 32'h4, 1'b0, 1'b0);
        tick(); check_state("seq2", 32'h8, 1'b0, 1'b0);

        stall = 1'b1;
        tick(); check_state("stall1", 32'h8, 1'b0, 1'b0);
        tick(); check_state("stall2", 32'h8, 1'b0, 1'b0);
        stall = 1'b0;
        tick(); check_state("seq3", 32'hC, 1'b0, 1'b0);
        tick(); check_state("seq4", 32'h10, 1'b0, 1'b0);

        // Branch beats jump when both are resolved together.
        branch_taken = 1'b1; branch_target = 32'h100;
        jump         = 1'b1; jump_target   = 32'h200;
        tick(); check_state("br_over_jmp", 32'h100, 1'b0, 1'b0);

        clear_ctrl();
        jump = 1'b1; jump_target = 32'h203;
        tick(); check_state("jmp_misal", 32'h200, 1'b0, 1'b1);
        clear_ctrl();
        tick(); check_state("misal_clear", 32'h204, 1'b0, 1'b0);

        // Only the selected target's low bits matter.
        branch_taken = 1'b1; branch_target = 32'h300;
        jump         = 1'b1; jump_target   = 32'h201;
        tick(); check_state("unsel_misal", 32'h300, 1'b0, 1'b0);

        clear_ctrl();
        branch_taken = 1'b1; branch_target = 32'h102;
        tick(); check_state("br_misal", 32'h100, 1'b0, 1'b1);

        clear_ctrl();
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        check("wrap_top.pc",       pc,       32'hFFFF_FFFC);
        check("wrap_top.pc_plus4", pc_plus4, 32'h0000_0000);
        clear_ctrl();
        tick(); check_state("wrap", 32'h0, 1'b0, 1'b0);

        // HALT on the squashed path of a taken branch must not halt.
        halt = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        tick(); check_state("halt_squashed", 32'h40, 1'b0, 1'b0);

        clear_ctrl();
        enable = 1'b0; branch_taken = 1'b1; branch_target = 32'h80;
        tick(); check_state("disabled_br", 32'h40, 1'b0, 1'b0);

        clear_ctrl();
        enable = 1'b1;
        tick(); check_state("step_on", 32'h44, 1'b0, 1'b0);
        enable = 1'b0;
        tick(); check_state("step_off", 32'h44, 1'b0, 1'b0);

        enable = 1'b1; jump = 1'b1; jump_target = 32'h20;
        tick(); check_state("to_0x20", 32'h20, 1'b0, 1'b0);

        clear_ctrl();
        halt = 1'b1;
        tick(); check_state("halt", 32'h20, 1'b1, 1'b0);

        clear_ctrl();
        branch_taken = 1'b1; branch_target = 32'h80;
        tick(); check_state("halted_br", 32'h20, 1'b1, 1'b0);
        tick(); check_state("halted_hold", 32'h20, 1'b1, 1'b0);

        // Reset overrides the still-asserted branch.
        reset = 1'b1;
        tick(); check_state("reset_halted", 32'h0, 1'b0, 1'b0);

        reset = 1'b0;
        clear_ctrl();
        tick(); check_state("post_reset", 32'h4, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
